gpio_ctrl: RTL
==============

# gpio_ctrl

Parametrised general-purpose I/O controller, the successor to the fixed-width GPIO peripheral on the processor's peripheral bus. It provides configurable input, output and bidirectional channel counts, with two-flop synchronisers on every input. It also supports atomic set/clear of outputs and optional per-channel any-edge interrupts on the input channels, signalled to the interrupt controller on `irq`. It attaches to the same chip-select/address-strobe bus as the other peripherals.

## Interface
- `IN_CH`, default 4: input-only channels, 1..32.
- `OUT_CH`, default 18: output-only channels, 1..32.
- `IO_CH`, default 16: bidirectional channels, 1..32.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cs_` in 1: chip select, active low.
- `as_` in 1: address strobe, active low.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 3: register word address.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data.
- `rdy_` out 1: access acknowledge, active low.
- `gpio_in` in IN_CH: input pins.
- `gpio_out` out OUT_CH: output pins.
- `gpio_io` inout IO_CH: bidirectional pins.
- `irq` out 1: interrupt request, active high.

## Operation
- Access occurs when `cs_`=0 and `as_`=0.
- Register map:
  - 0 IN_DATA (R): synchronised `gpio_in`.
  - 1 OUT_DATA (R/W).
  - 2 IO_DATA: R returns synchronised pins; W loads io_out.
  - 3 IO_DIR (R/W): bit 1 = drive, 0 = hi-Z.
  - 4 OUT_SET: W1S on OUT_DATA; reads as OUT_DATA.
  - 5 OUT_CLR: W1C on OUT_DATA; reads as OUT_DATA.
  - 6 IRQ_EN (R/W).
  - 7 IRQ_STAT: R; W1C.
- Width rules:
  - Bits above a register's channel count read 0.
  - Writes use `wr_data[CH-1:0]`; upper bits are ignored.
- `gpio_io[i]` = io_out[i] when IO_DIR[i]=1, else 1'bz.
- Synchronisers: `gpio_in` and `gpio_io` each pass through two flops (s1, s2). A third flop s3 holds the previous s2 for edge detection.
- Edge detection: edge[i] = s2[i] ^ s3[i]. An edge sets IRQ_STAT[i] regardless of IRQ_EN.
- `irq` = registered OR of (IRQ_STAT & IRQ_EN).
- Simultaneous events:
  - Edge and W1C on the same IRQ_STAT bit in the same cycle: the set wins and the bit stays 1.
  - Writing IRQ_EN does not clear IRQ_STAT.
- Reset values:
  - `rd_data`=0, `rdy_`=1, `gpio_out`=0, `irq`=0.
  - io_out=0, IO_DIR=0 (all pins hi-Z), IRQ_EN=0, IRQ_STAT=0.
  - s1/s2/s3=0.
- Reset during an access aborts it: no register update, and `rdy_`=1 on the following cycle.

## Timing
- Every access completes in one cycle.
  - `rdy_` goes low the cycle after the sampling edge, for one cycle per accessed cycle.
  - `rd_data` is valid in the same cycle as `rdy_`=0 on a read, and 0 otherwise.
- Write effect: the register updates at the sampling edge. Pins reflect the new value in the following cycle.
- Back-to-back accesses (strobe held low) are serviced every cycle.
- Input latency, for a pin change sampled into s1 at edge N:
  - IN_DATA/IO_DATA reflect it at N+1.
  - IRQ_STAT is set at N+2.
  - `irq` rises at N+3 if enabled.
- A W1C with no concurrent edge clears the bit at the write edge; `irq` falls one cycle later.
- A pulse narrower than one clock may be missed; this is not required to be detected.

## Configuration
- `GPIO_IRQ_EN` defined:
  - s3, IRQ_EN, IRQ_STAT and `irq` logic are present as above.
- `GPIO_IRQ_EN` undefined:
  - Addresses 6/7 read 0 and writes to them are ignored.
  - `irq` is tied 0; s3 is omitted.
  - All other behaviour is unchanged.

## Test plan
- Reset: assert `reset` for 2 cycles.
  - Expected: all outputs at reset values, `gpio_io` all Z, reads of 0..7 return 0 except IN_DATA (current synced pins).
- Output set/clear:
  - Write OUT_DATA=0x3_0F0F, then OUT_SET=0x0_00F0, then OUT_CLR=0x0_000F.
  - Expected: `gpio_out`=0x3_0FF0; OUT_DATA reads 0x3_0FF0; `wr_data` bits above 17 are ignored.
- Bidirectional direction:
  - IO_DIR=0x00FF, IO_DATA=0xA5A5; drive external 0x3C on the upper byte.
  - Expected: `gpio_io`[7:0]=0xA5, upper byte undriven by the block; after ≥2 cycles IO_DATA reads 0x3CA5.
- Edge interrupt:
  - IRQ_EN=0x1; toggle `gpio_in`[0] 0→1.
  - Expected: IRQ_STAT=0x1 at N+2, `irq`=1 at N+3; W1C 0x1 gives `irq`=0 one cycle later.
  - Toggle `gpio_in`[1] with its enable clear: IRQ_STAT[1]=1, `irq` stays 0.
- W1C/edge collision: W1C on IRQ_STAT[2] in the same cycle that edge[2] asserts.
  - Expected: IRQ_STAT[2] remains 1.
- Handshake/reset mid-access:
  - Hold `cs_`/`as_` low for 3 cycles of reads: 3 consecutive `rdy_`=0 cycles.
  - Assert `reset` with a write pending: register unchanged, `rdy_`=1.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised GPIO (input / output / bidirectional) on the cs_/as_ peripheral bus.
// Build option GPIO_IRQ_EN adds per-input any-edge interrupts (IRQ_EN, IRQ_STAT, irq).

module gpio_ctrl #(
  parameter int IN_CH  = 4,
  parameter int OUT_CH = 18,
  parameter int IO_CH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [2:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  input  logic [IN_CH-1:0]  gpio_in,
  output logic [OUT_CH-1:0] gpio_out,
  inout  wire  [IO_CH-1:0]  gpio_io,
  output logic              irq
);

  localparam logic [2:0] A_IN_DATA  = 3'd0;
  localparam logic [2:0] A_OUT_DATA = 3'd1;
  localparam logic [2:0] A_IO_DATA  = 3'd2;
  localparam logic [2:0] A_IO_DIR   = 3'd3;
  localparam logic [2:0] A_OUT_SET  = 3'd4;
  localparam logic [2:0] A_OUT_CLR  = 3'd5;
  localparam logic [2:0] A_IRQ_EN   = 3'd6;
  localparam logic [2:0] A_IRQ_STAT = 3'd7;

  // Handshake: an access is any cycle with cs_=0 and as_=0 at the clock edge; it is
  // acknowledged by rdy_=0 for exactly the next cycle, with rd_data valid then on reads.
  logic w_access;
  logic w_wr;
  assign w_access = ~cs_ & ~as_;
  assign w_wr     = w_access & ~rw;

  logic [IN_CH-1:0]  r_in_s1, r_in_s2;
  logic [IO_CH-1:0]  r_io_s1, r_io_s2;
  logic [IO_CH-1:0]  r_io_out, r_io_dir;
  logic [OUT_CH-1:0] r_out_data;
  logic [31:0]       r_rd_data;
  logic              r_rdy_n;
  logic [31:0]       w_rd_mux;
  logic [31:0]       w_irq_en_rd, w_irq_stat_rd;
  logic              w_unused_wr;

  assign w_unused_wr = ^wr_data;

`ifdef GPIO_IRQ_EN
  logic [IN_CH-1:0] r_in_s3, r_irq_en, r_irq_stat;
  logic [IN_CH-1:0] w_edge, w_stat_clr;
  logic             r_irq;

  assign w_edge     = r_in_s2 ^ r_in_s3;
  assign w_stat_clr = (w_wr && addr == A_IRQ_STAT) ? wr_data[IN_CH-1:0] : '0;

  // A new edge is ORed in after the W1C mask so it survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_s3    <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_in_s3    <= r_in_s2;
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_edge;
      r_irq      <= |(r_irq_stat & r_irq_en);
      if (w_wr && addr == A_IRQ_EN) r_irq_en <= wr_data[IN_CH-1:0];
    end
  end

  assign w_irq_en_rd   = 32'(r_irq_en);
  assign w_irq_stat_rd = 32'(r_irq_stat);
  assign irq           = r_irq;
`else
  assign w_irq_en_rd   = '0;
  assign w_irq_stat_rd = '0;
  assign irq           = 1'b0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      A_IN_DATA:  w_rd_mux = 32'(r_in_s2);
      A_OUT_DATA: w_rd_mux = 32'(r_out_data);
      A_IO_DATA:  w_rd_mux = 32'(r_io_s2);
      A_IO_DIR:   w_rd_mux = 32'(r_io_dir);
      A_OUT_SET:  w_rd_mux = 32'(r_out_data);
      A_OUT_CLR:  w_rd_mux = 32'(r_out_data);
      A_IRQ_EN:   w_rd_mux = w_irq_en_rd;
      A_IRQ_STAT: w_rd_mux = w_irq_stat_rd;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_s1    <= '0;
      r_in_s2    <= '0;
      r_io_s1    <= '0;
      r_io_s2    <= '0;
      r_io_out   <= '0;
      r_io_dir   <= '0;
      r_out_data <= '0;
      r_rd_data  <= '0;
      r_rdy_n    <= 1'b1;
    end else begin
      r_in_s1   <= gpio_in;
      r_in_s2   <= r_in_s1;
      r_io_s1   <= gpio_io;
      r_io_s2   <= r_io_s1;
      r_rdy_n   <= ~w_access;
      r_rd_data <= (w_access && rw) ? w_rd_mux : '0;
      if (w_wr) begin
        case (addr)
          A_OUT_DATA: r_out_data <= wr_data[OUT_CH-1:0];
          A_IO_DATA:  r_io_out   <= wr_data[IO_CH-1:0];
          A_IO_DIR:   r_io_dir   <= wr_data[IO_CH-1:0];
          A_OUT_SET:  r_out_data <= r_out_data | wr_data[OUT_CH-1:0];
          A_OUT_CLR:  r_out_data <= r_out_data & ~wr_data[OUT_CH-1:0];
          default:    ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < IO_CH; g++) begin : g_io_drv
    assign gpio_io[g] = r_io_dir[g] ? r_io_out[g] : 1'bz;
  end

  assign gpio_out = r_out_data;
  assign rd_data  = r_rd_data;
  assign rdy_     = r_rdy_n;

endmodule
